// File: rtl/udp_tx_header_builder_if.sv
// UDP_INPUT_HEADER_IF: header bundle handed to the UDP TX stack; the field set matches UDP_OUTPUT_HEADER_IF.
interface UDP_INPUT_HEADER_IF;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [47:0] eth_dest_mac;
   logic [47:0] eth_src_mac;
   logic [15:0] eth_type;
   logic [3:0]  ip_version;
   logic [3:0]  ip_ihl;
   logic [5:0]  ip_dscp;
   logic [1:0]  ip_ecn;
   logic [15:0] ip_length;
   logic [15:0] ip_identification;
   logic [2:0]  ip_flags;
   logic [12:0] ip_fragment_offset;
   logic [7:0]  ip_ttl;
   logic [7:0]  ip_protocol;
   logic [15:0] ip_header_checksum;
   logic [31:0] ip_source_ip;
   logic [31:0] ip_dest_ip;
   logic [15:0] source_port;
   logic [15:0] dest_port;
   logic [15:0] length;
   logic [15:0] checksum;
   modport Output (
      output hdr_valid, eth_dest_mac, eth_src_mac, eth_type, ip_version, ip_ihl, ip_dscp, ip_ecn,
             ip_length, ip_identification, ip_flags, ip_fragment_offset, ip_ttl, ip_protocol,
             ip_header_checksum, ip_source_ip, ip_dest_ip, source_port, dest_port, length, checksum,
      input  hdr_ready
   );
   modport Input (
      input  hdr_valid, eth_dest_mac, eth_src_mac, eth_type, ip_version, ip_ihl, ip_dscp, ip_ecn,
             ip_length, ip_identification, ip_flags, ip_fragment_offset, ip_ttl, ip_protocol,
             ip_header_checksum, ip_source_ip, ip_dest_ip, source_port, dest_port, length, checksum,
      output hdr_ready
   );
endinterface

// File: rtl/udp_tx_header_builder.sv
// udp_tx_header_builder: builds a full Ethernet/IPv4/UDP header with a serially accumulated IPv4 checksum
module udp_tx_header_builder #(
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP    = 32'hC0A8_0001,
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [47:0] req_dest_mac,
  input  logic [31:0] req_dest_ip,
  input  logic [15:0] req_source_port,
  input  logic [15:0] req_dest_port,
  input  logic [15:0] req_payload_length,
  output logic        err_oversize,
  UDP_INPUT_HEADER_IF.Output hdr
);
  typedef enum logic [2:0] {IDLE, CHECK, SUM, FOLD, OUT} state_t;
  state_t      state_q, state_d;
  logic [15:0] id_q, id_d, ip_id_q, ip_id_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] dip_q, dip_d;
  logic [15:0] sport_q, sport_d, dport_q, dport_d;
  logic [15:0] len_q, len_d, ip_len_q, ip_len_d, csum_q, csum_d;
  logic        err_q, err_d;
  logic [15:0] word, s2;
  logic [16:0] s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= '0;
      ip_id_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mac_q    <= '0;
      dip_q    <= '0;
      sport_q  <= '0;
      dport_q  <= '0;
      len_q    <= '0;
      ip_len_q <= '0;
      csum_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ip_id_q  <= ip_id_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mac_q    <= mac_d;
      dip_q    <= dip_d;
      sport_q  <= sport_d;
      dport_q  <= dport_d;
      len_q    <= len_d;
      ip_len_q <= ip_len_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    case (cnt_q)
      4'd0:    word = 16'h4500;
      4'd1:    word = ip_len_q;
      4'd2:    word = ip_id_q;
      4'd3:    word = 16'h4000;
      4'd4:    word = {IP_TTL, 8'h11};
      4'd6:    word = LOCAL_IP[31:16];
      4'd7:    word = LOCAL_IP[15:0];
      4'd8:    word = dip_q[31:16];
      4'd9:    word = dip_q[15:0];
      default: word = 16'h0000;
    endcase
  end
  assign s1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign s2 = s1[15:0] + {15'd0, s1[16]};
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ip_id_d  = ip_id_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mac_d    = mac_q;
    dip_d    = dip_q;
    sport_d  = sport_q;
    dport_d  = dport_q;
    len_d    = len_q;
    ip_len_d = ip_len_q;
    csum_d   = csum_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        mac_d    = req_dest_mac;
        dip_d    = req_dest_ip;
        sport_d  = req_source_port;
        dport_d  = req_dest_port;
        len_d    = req_payload_length + 16'd8;
        ip_len_d = req_payload_length + 16'd28;
        ip_id_d  = id_q;
        err_d    = req_payload_length > MAX_PAYLOAD;
        state_d  = CHECK;
      end
      CHECK: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = err_q ? IDLE : SUM;
      end
      SUM: begin
        acc_d   = acc_q + {4'd0, word};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd9) ? FOLD : SUM;
      end
      FOLD: begin
        csum_d  = ~s2;
        state_d = OUT;
      end
      OUT: if (hdr.hdr_ready) begin
        id_d    = id_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign req_ready              = state_q == IDLE;
  assign err_oversize           = err_q;
  assign hdr.hdr_valid          = state_q == OUT;
  assign hdr.eth_dest_mac       = mac_q;
  assign hdr.eth_src_mac        = LOCAL_MAC;
  assign hdr.eth_type           = 16'h0800;
  assign hdr.ip_version         = 4'd4;
  assign hdr.ip_ihl             = 4'd5;
  assign hdr.ip_dscp            = 6'd0;
  assign hdr.ip_ecn             = 2'd0;
  assign hdr.ip_length          = ip_len_q;
  assign hdr.ip_identification  = ip_id_q;
  assign hdr.ip_flags           = 3'b010;
  assign hdr.ip_fragment_offset = 13'd0;
  assign hdr.ip_ttl             = IP_TTL;
  assign hdr.ip_protocol        = 8'h11;
  assign hdr.ip_header_checksum = csum_q;
  assign hdr.ip_source_ip       = LOCAL_IP;
  assign hdr.ip_dest_ip         = dip_q;
  assign hdr.source_port        = sport_q;
  assign hdr.dest_port          = dport_q;
  assign hdr.length             = len_q;
  assign hdr.checksum           = 16'h0000;
endmodule
